hs_burst_tx: RTL and testbench

Valid/ready burst transmitter: the upstream driver for the 4-bit valid/ready handshake stream used across the bus fabric. On a start request it emits a burst of consecutive data beats (base, base+1, …), holding each beat stable until the downstream stage accepts it. It sits in front of the handshake pipeline register and drives its `valid_i`/`data_i` inputs while honouring its `ready_o` back-pressure. A busy flag and a one-cycle done pulse report burst completion to the control logic.

---
 rtl/hs_pkg.sv | 13 +
 rtl/hs_burst_tx.sv | 141 ++++++++++++++
 tb/tb_hs_burst_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/hs_pkg.sv
// Shared definitions for the 4-bit valid/ready handshake stream blocks.
package hs_pkg;

  localparam int unsigned HS_DATA_W = 4;
  localparam int unsigned HS_LEN_W  = 4;

  typedef enum logic [1:0] {
    HS_TX_IDLE = 2'd0,
    HS_TX_SEND = 2'd1,
    HS_TX_GAP  = 2'd2
  } hs_tx_state_e;

endpackage

// File: rtl/hs_burst_tx.sv
// Valid/ready burst transmitter: emits base, base+1, ... for a latched beat count.
// Optional inter-beat idle gap is enabled by defining HS_TX_GAP_EN.
module hs_burst_tx
  import hs_pkg::*;
#(
  parameter int unsigned DATA_W = HS_DATA_W,
  parameter int unsigned LEN_W  = HS_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [DATA_W-1:0] base_i,
`ifdef HS_TX_GAP_EN
  input  logic [1:0]        gap_i,
`endif
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o
);

  // One extra bit so a zero length field can hold the full 2^LEN_W count.
  localparam int unsigned RW = LEN_W + 1;
  localparam logic [RW-1:0] FULL_CNT = RW'(1) << LEN_W;

  hs_tx_state_e      state_q, state_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef HS_TX_GAP_EN
  logic [1:0]        gap_q, gap_d;
  logic [1:0]        gcnt_q, gcnt_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HS_TX_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef HS_TX_GAP_EN
      gap_q   <= 2'd0;
      gcnt_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef HS_TX_GAP_EN
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are the registered copies.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
`ifdef HS_TX_GAP_EN
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
`endif
    case (state_q)
      HS_TX_IDLE: begin
        if (start_i) begin
          state_d = HS_TX_SEND;
          data_d  = base_i;
          rem_d   = (len_i == '0) ? FULL_CNT : RW'(len_i);
          valid_d = 1'b1;
          last_d  = (len_i == LEN_W'(1));
`ifdef HS_TX_GAP_EN
          gap_d   = gap_i;
`endif
        end
      end
      HS_TX_SEND: begin
        if (valid_q && ready_i) begin
          if (last_q) begin
            state_d = HS_TX_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            data_d  = data_q + DATA_W'(1);
            rem_d   = rem_q - RW'(1);
            last_d  = (rem_q == RW'(2));
`ifdef HS_TX_GAP_EN
            if (gap_q != 2'd0) begin
              state_d = HS_TX_GAP;
              valid_d = 1'b0;
              gcnt_d  = gap_q;
            end
`endif
          end
        end
      end
`ifdef HS_TX_GAP_EN
      HS_TX_GAP: begin
        if (gcnt_q <= 2'd1) begin
          state_d = HS_TX_SEND;
          valid_d = 1'b1;
          gcnt_d  = 2'd0;
        end else begin
          gcnt_d = gcnt_q - 2'd1;
        end
      end
`endif
      default: begin
        state_d = HS_TX_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != HS_TX_IDLE);
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_hs_burst_tx.sv
// Directed bench for hs_burst_tx: per-cycle vector table plus hand-written corner sequences.
module tb_hs_burst_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [3:0] len_i;
  logic [3:0] base_i;
`ifdef HS_TX_GAP_EN
  logic [1:0] gap_i;
`endif
  logic       valid_o;
  logic [3:0] data_o;
  logic       last_o;
  logic       ready_i;
  logic       busy_o;
  logic       done_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hs_burst_tx dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_i),
    .len_i   (len_i),
    .base_i  (base_i),
`ifdef HS_TX_GAP_EN
    .gap_i   (gap_i),
`endif
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .ready_i (ready_i),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  typedef struct {
    logic       rst;
    logic       start;
    logic [3:0] len;
    logic [3:0] base;
    logic       ready;
    logic       chk_data;
    logic       e_valid;
    logic [3:0] e_data;
    logic       e_last;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] d,
                           input logic chk_d, input logic l, input logic b, input logic dn);
    check({tag, ".valid"}, 32'(valid_o), 32'(v));
    if (chk_d) check({tag, ".data"}, 32'(data_o), 32'(d));
    check({tag, ".last"}, 32'(last_o), 32'(l));
    check({tag, ".busy"}, 32'(busy_o), 32'(b));
    check({tag, ".done"}, 32'(done_o), 32'(dn));
  endtask

  function automatic vec_t mk(logic r, logic s, logic [3:0] ln, logic [3:0] bs, logic rd,
                              logic cd, logic v, logic [3:0] d, logic l, logic b, logic dn);
    vec_t t;
    t.rst = r; t.start = s; t.len = ln; t.base = bs; t.ready = rd;
    t.chk_data = cd; t.e_valid = v; t.e_data = d; t.e_last = l; t.e_busy = b; t.e_done = dn;
    return t;
  endfunction

  initial begin
    // Basic burst len=3 base=5
    vecs[0]  = mk(0, 1, 4'd3, 4'h5, 1, 1, 1, 4'h5, 0, 1, 0);
    vecs[1]  = mk(0, 0, 4'd0, 4'h0, 1, 1, 1, 4'h6, 0, 1, 0);
    vecs[2]  = mk(0, 0, 4'd0, 4'h0, 1, 1, 1, 4'h7, 1, 1, 0);
    vecs[3]  = mk(0, 0, 4'd0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 1);
    vecs[4]  = mk(0, 0, 4'd0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0);
    // Back-pressure len=4 base=0, ready 3 low / 3 high
    vecs[5]  = mk(0, 1, 4'd4, 4'h0, 0, 1, 1, 4'h0, 0, 1, 0);
    vecs[6]  = mk(0, 0, 4'd0, 4'h0, 0, 1, 1, 4'h0, 0, 1, 0);
    vecs[7]  = mk(0, 0, 4'd0, 4'h0, 0, 1, 1, 4'h0, 0, 1, 0);
    vecs[8]  = mk(0, 0, 4'd0, 4'h0, 1, 1, 1, 4'h1, 0, 1, 0);
    vecs[9]  = mk(0, 0, 4'd0, 4'h0, 1, 1, 1, 4'h2, 0, 1, 0);
    vecs[10] = mk(0, 0, 4'd0, 4'h0, 1, 1, 1, 4'h3, 1, 1, 0);
    vecs[11] = mk(0, 0, 4'd0, 4'h0, 0, 1, 1, 4'h3, 1, 1, 0);
    vecs[12] = mk(0, 0, 4'd0, 4'h0, 0, 1, 1, 4'h3, 1, 1, 0);
    vecs[13] = mk(0, 0, 4'd0, 4'h0, 0, 1, 1, 4'h3, 1, 1, 0);
    vecs[14] = mk(0, 0, 4'd0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 1);
    vecs[15] = mk(0, 0, 4'd0, 4'h0, 1, 0, 0, 4'h0, 0, 0, 0);
    // Reset mid-burst len=8 base=0
    vecs[16] = mk(0, 1, 4'd8, 4'h0, 1, 1, 1, 4'h0, 0, 1, 0);
    vecs[17] = mk(0, 0, 4'd0, 4'h0, 1, 1, 1, 4'h1, 0, 1, 0);
    vecs[18] = mk(0, 0, 4'd0, 4'h0, 1, 1, 1, 4'h2, 0, 1, 0);
    vecs[19] = mk(1, 0, 4'd0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0);
    vecs[20] = mk(0, 0, 4'd0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0);
    vecs[21] = mk(0, 0, 4'd0, 4'h0, 1, 1, 0, 4'h0, 0, 0, 0);

    rst = 1'b1; start_i = 1'b0; len_i = '0; base_i = '0; ready_i = 1'b0;
`ifdef HS_TX_GAP_EN
    gap_i = 2'd0;
`endif
    tick();
    tick();
    check_out("reset", 0, 4'h0, 1, 0, 0, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst; start_i = vecs[i].start; len_i = vecs[i].len;
      base_i = vecs[i].base; ready_i = vecs[i].ready;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_data, vecs[i].chk_data,
                vecs[i].e_last, vecs[i].e_busy, vecs[i].e_done);
    end
    rst = 1'b0; start_i = 1'b0;

    // Zero length = 16 beats, wrapping E, F, 0 ... D
    start_i = 1'b1; len_i = 4'd0; base_i = 4'hE; ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] exp_d;
      exp_d = 4'hE + 4'(k);
      check_out($sformatf("wrap%0d", k), 1, exp_d, 1, (k == 15), 1, 0);
      tick();
    end
    check_out("wrap_done", 0, 4'h0, 0, 0, 0, 1);
    tick();

    // Mid-burst start ignored, then start in the done cycle
    start_i = 1'b1; len_i = 4'd2; base_i = 4'h3;
    tick();
    check_out("b2b_a0", 1, 4'h3, 1, 0, 1, 0);
    len_i = 4'd5; base_i = 4'h9;
    tick();
    check_out("b2b_ign", 1, 4'h4, 1, 1, 1, 0);
    start_i = 1'b0;
    tick();
    check_out("b2b_done", 0, 4'h0, 0, 0, 0, 1);
    start_i = 1'b1; len_i = 4'd1; base_i = 4'hA;
    tick();
    check_out("b2b_b0", 1, 4'hA, 1, 1, 1, 0);
    start_i = 1'b0;
    tick();
    check_out("b2b_bdone", 0, 4'h0, 0, 0, 0, 1);
    tick();
    check_out("b2b_idle", 0, 4'h0, 0, 0, 0, 0);

`ifdef HS_TX_GAP_EN
    // gap=2: valid pattern 1,0,0,1,0,0,1
    start_i = 1'b1; len_i = 4'd3; base_i = 4'h1; gap_i = 2'd2;
    tick();
    start_i = 1'b0; gap_i = 2'd0;
    for (int k = 0; k < 7; k++) begin
      check($sformatf("gap_valid%0d", k), 32'(valid_o), 32'((k % 3) == 0));
      if ((k % 3) == 0)
        check($sformatf("gap_data%0d", k), 32'(data_o), 32'(1 + k / 3));
      check($sformatf("gap_busy%0d", k), 32'(busy_o), 1);
      tick();
    end
    check_out("gap_done", 0, 4'h0, 0, 0, 0, 1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
